// File: rtl/ppu_video_timing_if.sv
// ============================================================================
// ppu_video_timing_if : pixel stream from the PPU output stage to the video sink
// Revision 1.0
// ============================================================================
`default_nettype none

interface ppu_video_timing_if;
  logic [7:0] pixel;
  logic       pixel_en;
  logic       frame;

  modport master (
    output pixel,
    output pixel_en,
    output frame
  );

  modport slave (
    input pixel,
    input pixel_en,
    input frame
  );
endinterface

`default_nettype wire

// File: rtl/ppu_video_timing.sv
// ============================================================================
// ppu_video_timing : 2C02 dot/scanline counters, odd-frame skip, vblank/NMI
//                    flag and registered pixel output stage
// Revision 1.0
// ============================================================================
`default_nettype none

module ppu_video_timing #(
  parameter int DOTS     = 341,
  parameter int LINES    = 262,
  parameter int VIS_W    = 256,
  parameter int VIS_H    = 240,
  parameter int VBL_LINE = 241,
  parameter int PRE_LINE = 261
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      render_en,
  input  logic                      nmi_en,
  input  logic                      status_rd,
  input  logic [7:0]                pal_idx,
  output logic [8:0]                dot,
  output logic [8:0]                line,
  output logic                      odd_frame,
  output logic                      status_vbl,
  output logic                      vblank,
  output logic                      nmi_n,
  ppu_video_timing_if.master        vid
);

  localparam logic [8:0] LAST_DOT   = 9'(DOTS - 1);
  localparam logic [8:0] SKIP_DOT   = 9'(DOTS - 2);
  localparam logic [8:0] LAST_LINE  = 9'(LINES - 1);
  localparam logic [8:0] PRE_L      = 9'(PRE_LINE);
  localparam logic [8:0] VBL_L      = 9'(VBL_LINE);
  localparam logic [8:0] VIS_W_L    = 9'(VIS_W);
  localparam logic [8:0] VIS_H_L    = 9'(VIS_H);

  logic       end_of_line;
  logic       on_pre_line;
  logic       skip_dot;
  logic       wrap_frame;
  logic       visible;
  logic       vbl_set;
  logic       vbl_clr;

  logic [7:0] pixel_q;
  logic       pixel_en_q;
  logic       frame_q;

  // ------------------------------------------------------------------------
  // Raster counters
  // ------------------------------------------------------------------------
  assign end_of_line = (dot == LAST_DOT);
  assign on_pre_line = (line == PRE_L);

  // The last dot of the pre-render line is dropped on odd frames while rendering.
  assign skip_dot    = on_pre_line && (dot == SKIP_DOT) && odd_frame && render_en;
  assign wrap_frame  = skip_dot || (end_of_line && (line == LAST_LINE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dot       <= '0;
      line      <= '0;
      odd_frame <= 1'b0;
    end else if (wrap_frame) begin
      dot       <= '0;
      line      <= '0;
      odd_frame <= ~odd_frame;
    end else if (end_of_line) begin
      dot       <= '0;
      line      <= line + 9'd1;
    end else begin
      dot       <= dot + 9'd1;
    end
  end

  // ------------------------------------------------------------------------
  // Vblank flag and NMI
  // ------------------------------------------------------------------------
  assign vbl_set = (line == VBL_L) && (dot == 9'd1);
  assign vbl_clr = on_pre_line && (dot == 9'd1);

  // A read landing on the set cycle wins: the flag is never raised that frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblank <= 1'b0;
    end else if (vbl_set && !status_rd) begin
      vblank <= 1'b1;
    end else if (vbl_clr) begin
      vblank <= 1'b0;
    end else if (status_rd) begin
      vblank <= 1'b0;
    end
  end

  assign status_vbl = vblank;
  assign nmi_n      = ~(vblank & nmi_en);

  // ------------------------------------------------------------------------
  // Pixel output stage
  // ------------------------------------------------------------------------
  assign visible = (line < VIS_H_L) && (dot >= 9'd1) && (dot <= VIS_W_L);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_q    <= '0;
      pixel_en_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      pixel_en_q <= visible;
      frame_q    <= on_pre_line;
      if (visible) begin
        pixel_q <= pal_idx;
      end
    end
  end

  assign vid.pixel    = pixel_q;
  assign vid.pixel_en = pixel_en_q;
  assign vid.frame    = frame_q;

endmodule

`default_nettype wire

// File: doc/ppu_video_timing.md
# ppu_video_timing

Dot/scanline timing generator and pixel output stage of the 2C02 PPU. Counts one PPU dot per `clk` over the 341×262 NTSC raster and applies the odd-frame dot skip. Maintains the vblank flag and NMI, and registers the palette index from the pixel mux into the `pixel`/`pixel_en`/`frame` stream consumed directly by the downstream video sink.

## Interface
- `DOTS`, 341, dots per scanline (0..DOTS-1)
- `LINES`, 262, scanlines per frame (0..LINES-1)
- `VIS_W`, 256, visible pixels per line, output on dots 1..VIS_W
- `VIS_H`, 240, visible lines 0..VIS_H-1
- `VBL_LINE`, 241, line on which vblank is set
- `PRE_LINE`, 261, pre-render line; vblank cleared here

Ports:
- `clk`  in  1  PPU dot clock; one dot per rising edge
- `rst`  in  1  asynchronous, active-low reset
- `render_en`  in  1  rendering enabled (PPUMASK bg|spr); gates the odd-frame skip
- `nmi_en`  in  1  PPUCTRL bit 7
- `status_rd`  in  1  one-cycle pulse: CPU read of $2002 this cycle
- `pal_idx`  in  8  palette index from pixel mux for the current dot
- `dot`  out  9  current dot counter
- `line`  out  9  current scanline counter
- `odd_frame`  out  1  frame parity
- `status_vbl`  out  1  vblank value returned to the $2002 read in this cycle
- `vblank`  out  1  vblank flag
- `nmi_n`  out  1  active-low NMI to CPU
- `pixel`  out  8  registered palette index
- `pixel_en`  out  1  `pixel` valid this cycle
- `frame`  out  1  high for the whole pre-render line

## Operation
- Reset (`rst`=0, takes effect immediately, no clock needed): `dot`=0, `line`=0, `odd_frame`=0, `vblank`=0, `pixel`=0, `pixel_en`=0, `frame`=0; `nmi_n`=1.
- Counters advance every clock. `dot` increments, and at DOTS-1 wraps to 0 and `line` increments. `line` wraps from PRE_LINE to 0.
- Odd-frame skip: at `line`=PRE_LINE, `dot`=339 with `odd_frame`=1 and `render_en`=1, the next state is `line`=0, `dot`=0 (dot 340 skipped). `render_en` is sampled only in that cycle.
- `odd_frame` toggles on every transition into `line`=0 (normal or skipped wrap).
- Pixel stage, per edge:
  - `pixel_en` <= (`line`<VIS_H) && (1≤`dot`≤VIS_W).
  - `pixel` <= `pal_idx` when that term is true; otherwise `pixel` holds.
  - Exactly VIS_W×VIS_H `pixel_en` cycles per frame, raster order.
- `frame` <= (`line`==PRE_LINE). It therefore rises one cycle after the counter enters PRE_LINE, well ahead of line 0 dot 1.
- Vblank flag, priority highest first:
  1. Set at `line`=VBL_LINE, `dot`=1, unless `status_rd` is high in that same cycle. In that case the flag stays 0 for the whole frame (suppression).
  2. Clear at `line`=PRE_LINE, `dot`=1.
  3. Clear on `status_rd`.
- `status_vbl` = current `vblank` flag (combinational). A read in the set cycle returns 0.
- `nmi_n` = ~(`vblank` & `nmi_en`), combinational from the flag register and input. Raising `nmi_en` while the flag is set asserts NMI again. A read clears the flag and so releases NMI.

## Timing
- One dot per clock. Frame length is 89342 clocks. When the skip is taken it is 89341 (odd frame, `render_en`=1).
- Pixel latency is 1 cycle: `pal_idx` at dot d of a visible line appears on `pixel` with `pixel_en`=1 on the next cycle.
- The vblank flag reads 1 from the cycle after (VBL_LINE, 1) through the cycle of (PRE_LINE, 1) inclusive. It reads 0 from the next cycle.
- Set/clear/read take effect at the clock edge ending the qualifying cycle. Simultaneous read and PRE_LINE clear: the flag clears.
- The first frame after reset emits pixels before the first `frame` rise; the sink discards them, and that is acceptable.
- Reset asserted mid-line: all state returns to reset values asynchronously. Counting restarts at (0,0) on the first edge after release.

## Test plan
- Reset release, `render_en`=0: `frame` rises at clock 261×341+1 = 89002 after release. The next rise follows exactly 89342 clocks later, on both parities.
- `render_en`=1: successive `frame` rise spacing alternates 89341 / 89342 clocks. `odd_frame` toggles at each wrap.
- Drive `pal_idx` = `dot`[7:0] on visible lines:
  - 61440 `pixel_en` cycles per frame.
  - First pixel of each line = 0x01, last = 0x00 (dot 256 truncated).
  - `pixel_en`=0 on lines 240–261.
- `nmi_en`=1, no reads: `nmi_n` falls the cycle after (241,1) and rises the cycle after (261,1). `status_rd` at (245,10): `status_vbl`=1, and `nmi_n`=1 on the next cycle.
- `status_rd` exactly at (241,1): `status_vbl`=0, `vblank` stays 0, and `nmi_n` stays 1 through line 261. `status_rd` at (241,2): returns 1.
- Assert `rst` at (120,77): all outputs are at reset values immediately. After release, (0,0) is restored and the frame sequence repeats the first scenario.
